sram_wrap_l1_param: RTL and testbench

Parametrised next-generation L1 cache SRAM wrapper: a synchronous single-port storage array behind a valid/ready request port, with byte-masked writes and a fixed, parameter-set read latency.
Supports a pipelined mode (one request per cycle, several reads in flight) and a blocking mode (one outstanding read), plus an optional post-reset clear sequence.
Sits between the L1 cache controller and the storage array, replacing the fixed 64x1024 wrapper.

---
 rtl/sram_wrap_l1_param.sv | 135 +++++++++++++
 tb/tb_sram_wrap_l1_param.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_wrap_l1_param.sv
// Parametrised L1 SRAM wrapper: single-port array, byte-masked writes, optional zero-clear after reset.
// Latency: a read accepted on edge N shows rsp_valid/rsp_rdata in the cycle after edge N+READ_LATENCY-1.
// Backpressure: req_ready low while clearing and, in blocking mode, while a read is outstanding; no response stall.
module sram_wrap_l1_param #(
    parameter int DATA_WIDTH   = 64,
    parameter int ADDR_WIDTH   = 10,
    parameter int NUM_WMASKS   = DATA_WIDTH / 8,
    parameter int READ_LATENCY = 6,
    parameter int PIPELINED    = 1,
    parameter int INIT_CLEAR   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_WMASKS-1:0] req_wmask,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    if (DATA_WIDTH % 8 != 0 || READ_LATENCY < 1 || NUM_WMASKS != DATA_WIDTH / 8) begin : g_param_err
        $error("sram_wrap_l1_param: illegal DATA_WIDTH/NUM_WMASKS/READ_LATENCY");
    end

    typedef struct packed {
        logic                  vld;
        logic [DATA_WIDTH-1:0] dat;
    } slot_t;

    typedef enum logic [1:0] {ST_INIT, ST_READY, ST_WAIT} state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    state_t                state;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    slot_t                 pipe    [READ_LATENCY];
    slot_t                 pipe_in [READ_LATENCY];
    logic                  req_acc;
    logic                  rd_acc;
    logic                  wr_acc;
    logic                  clr_we;
    logic                  rsp_arrive;

    // Nothing is accepted on a reset edge, even if req_ready was still high.
    assign req_acc    = req_valid && req_ready && !rst;
    assign rd_acc     = req_acc && !req_we;
    assign wr_acc     = req_acc && req_we;
    assign clr_we     = (state == ST_INIT) && !rst;
    assign rsp_arrive = pipe_in[READ_LATENCY-1].vld;

    // Stage 0 captures array data on the acceptance edge; the last stage is the response register.
    always_comb begin
        pipe_in[0].vld = rd_acc;
        pipe_in[0].dat = mem[req_addr];
        for (int k = 1; k < READ_LATENCY; k++) begin
            pipe_in[k] = pipe[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < READ_LATENCY; k++) begin
                pipe[k] <= '0;
            end
        end else begin
            for (int k = 0; k < READ_LATENCY; k++) begin
                pipe[k].vld <= pipe_in[k].vld;
                if (pipe_in[k].vld) begin
                    pipe[k].dat <= pipe_in[k].dat;
                end
            end
        end
    end

    assign rsp_valid = pipe[READ_LATENCY-1].vld;
    assign rsp_rdata = pipe[READ_LATENCY-1].dat;

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_cnt] <= '0;
        end else if (wr_acc) begin
            for (int i = 0; i < NUM_WMASKS; i++) begin
                if (req_wmask[i]) begin
                    mem[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= (INIT_CLEAR != 0) ? ST_INIT : ST_READY;
            clr_cnt   <= '0;
            req_ready <= 1'b0;
            init_done <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == '1) begin
                        state     <= ST_READY;
                        req_ready <= 1'b1;
                        init_done <= 1'b1;
                    end
                end
                ST_READY: begin
                    init_done <= 1'b1;
                    // A latency-1 read completes on its own acceptance edge, so it never needs WAIT.
                    if (PIPELINED == 0 && rd_acc && !rsp_arrive) begin
                        state     <= ST_WAIT;
                        req_ready <= 1'b0;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (rsp_arrive) begin
                        state     <= ST_READY;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_READY;
                    req_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_wrap_l1_param.sv
// Bench for sram_wrap_l1_param: pipelined default instance against a cycle-level reference model,
// plus a blocking, no-clear instance driven by hand.
module tb_sram_wrap_l1_param;

    localparam int DW    = 64;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;
    localparam int LAT   = 6;
    localparam int AW_B  = 4;

    logic          clk = 1'b0;
    logic          rst;

    logic          a_valid, a_ready, a_we, a_rsp_valid, a_done;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata, a_rsp_rdata;
    logic [7:0]    a_wmask;

    logic            b_valid, b_ready, b_we, b_rsp_valid, b_done;
    logic [AW_B-1:0] b_addr;
    logic [DW-1:0]   b_wdata, b_rsp_rdata;
    logic [7:0]      b_wmask;

    always #5 clk = ~clk;

    sram_wrap_l1_param dut_a (
        .clk(clk), .rst(rst),
        .req_valid(a_valid), .req_ready(a_ready), .req_we(a_we), .req_addr(a_addr),
        .req_wdata(a_wdata), .req_wmask(a_wmask),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .init_done(a_done)
    );

    sram_wrap_l1_param #(.ADDR_WIDTH(AW_B), .PIPELINED(0), .INIT_CLEAR(0)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we), .req_addr(b_addr),
        .req_wdata(b_wdata), .req_wmask(b_wmask),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .init_done(b_done)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check1(input string name, input logic act, input logic want);
        n_total++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %b want %b", name, act, want);
    endtask

    task automatic check64(input string name, input logic [DW-1:0] act, input logic [DW-1:0] want);
        n_total++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, want);
    endtask

    task automatic check_int(input string name, input int act, input int want);
        n_total++;
        if (act == want) n_pass++;
        else $display("FAIL %s: got %0d want %0d", name, act, want);
    endtask

    // Reference model for dut_a: word array, outstanding responses with due edge, clear countdown.
    typedef struct {
        int            due;
        logic [DW-1:0] dat;
    } exp_t;

    logic [DW-1:0] m_mem [DEPTH];
    exp_t          exp_q [$];
    int            init_left = 0;
    logic          m_ready   = 1'b0;
    logic [DW-1:0] last_rd   = '0;
    int            cyc       = 0;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                            input logic [7:0] mask);
        logic [DW-1:0] r;
        r = old;
        for (int i = 0; i < 8; i++) begin
            if (mask[i]) r[8*i +: 8] = nw[8*i +: 8];
        end
        return r;
    endfunction

    task automatic step();
        exp_t e;
        @(posedge clk);
        cyc++;
        if (rst) begin
            exp_q.delete();
            last_rd   = '0;
            init_left = DEPTH;
            m_ready   = 1'b0;
        end else begin
            if (m_ready && a_valid) begin
                if (a_we) begin
                    m_mem[a_addr] = merge(m_mem[a_addr], a_wdata, a_wmask);
                end else begin
                    e.due = cyc + LAT - 1;
                    e.dat = m_mem[a_addr];
                    exp_q.push_back(e);
                end
            end
            if (init_left > 0) begin
                init_left--;
                if (init_left == 0) begin
                    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
                end
            end
            m_ready = (init_left == 0);
        end
        @(negedge clk);
        check1("a_ready", a_ready, m_ready);
        check1("a_init_done", a_done, m_ready);
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            check1("a_rsp_valid", a_rsp_valid, 1'b1);
            check64("a_rsp_rdata", a_rsp_rdata, exp_q[0].dat);
            last_rd = exp_q[0].dat;
            void'(exp_q.pop_front());
        end else begin
            check1("a_rsp_idle", a_rsp_valid, 1'b0);
            check64("a_rsp_hold", a_rsp_rdata, last_rd);
        end
    endtask

    task automatic drive_a(input logic v, input logic we, input int addr,
                           input logic [DW-1:0] wd, input logic [7:0] m);
        a_valid = v;
        a_we    = we;
        a_addr  = addr[AW-1:0];
        a_wdata = wd;
        a_wmask = m;
    endtask

    task automatic drive_b(input logic v, input logic we, input int addr,
                           input logic [DW-1:0] wd, input logic [7:0] m);
        b_valid = v;
        b_we    = we;
        b_addr  = addr[AW_B-1:0];
        b_wdata = wd;
        b_wmask = m;
    endtask

    task automatic read_chk(input string tag, input int addr, input logic [DW-1:0] want);
        drive_a(1'b1, 1'b0, addr, '0, '0);
        step();
        drive_a(1'b0, 1'b0, 0, '0, '0);
        repeat (LAT - 1) step();
        check1({tag, "_vld"}, a_rsp_valid, 1'b1);
        check64({tag, "_dat"}, a_rsp_rdata, want);
        step();
        check1({tag, "_pulse"}, a_rsp_valid, 1'b0);
    endtask

    // Collects three responses and checks values and the edge spacing between them.
    task automatic collect(input string tag, input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                           input logic [DW-1:0] e2, input int g1, input int g2);
        logic [DW-1:0] got [$];
        int            got_cyc [$];
        logic [DW-1:0] want [3];
        int            gap [3];
        want[0] = e0; want[1] = e1; want[2] = e2;
        gap[1]  = g1; gap[2]  = g2;
        for (int k = 0; k < 12; k++) begin
            step();
            if (a_rsp_valid) begin
                got.push_back(a_rsp_rdata);
                got_cyc.push_back(cyc);
            end
        end
        check_int({tag, "_count"}, got.size(), 3);
        for (int k = 0; k < 3 && k < got.size(); k++) begin
            check64($sformatf("%s_dat%0d", tag, k), got[k], want[k]);
            if (k > 0) check_int($sformatf("%s_gap%0d", tag, k), got_cyc[k] - got_cyc[k-1], gap[k]);
        end
    endtask

    typedef struct {
        logic          we;
        int            addr;
        logic [DW-1:0] wdata;
        logic [7:0]    wmask;
        logic [DW-1:0] exp;
    } vec_t;

    function automatic vec_t mkv(input logic we, input int addr, input logic [DW-1:0] wd,
                                 input logic [7:0] m, input logic [DW-1:0] e);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wd; v.wmask = m; v.exp = e;
        return v;
    endfunction

    vec_t vt [15];

    initial begin
        vt[0]  = mkv(1'b0, 5,    64'd0,                  8'h00, 64'd0);
        vt[1]  = mkv(1'b1, 48,   64'd77,                 8'hFF, 64'd0);
        vt[2]  = mkv(1'b1, 49,   64'd1,                  8'hFF, 64'd0);
        vt[3]  = mkv(1'b0, 48,   64'd0,                  8'h00, 64'd77);
        vt[4]  = mkv(1'b0, 49,   64'd0,                  8'h00, 64'd1);
        vt[5]  = mkv(1'b1, 48,   64'h1122334455667788,   8'hFF, 64'd0);
        vt[6]  = mkv(1'b1, 48,   64'hAAAAAAAAAAAAAAAA,   8'h0F, 64'd0);
        vt[7]  = mkv(1'b0, 48,   64'd0,                  8'h00, 64'h11223344AAAAAAAA);
        vt[8]  = mkv(1'b1, 48,   64'hFFFFFFFFFFFFFFFF,   8'h00, 64'd0);
        vt[9]  = mkv(1'b0, 48,   64'd0,                  8'h00, 64'h11223344AAAAAAAA);
        vt[10] = mkv(1'b1, 1023, 64'hDEADBEEF12345678,   8'hF0, 64'd0);
        vt[11] = mkv(1'b0, 1023, 64'd0,                  8'h00, 64'hDEADBEEF00000000);
        vt[12] = mkv(1'b1, 0,    64'h0102030405060708,   8'h81, 64'd0);
        vt[13] = mkv(1'b0, 0,    64'd0,                  8'h00, 64'h0100000000000008);
        vt[14] = mkv(1'b1, 48,   64'd77,                 8'hFF, 64'd0);

        rst = 1'b1;
        drive_a(1'b0, 1'b0, 0, '0, '0);
        drive_b(1'b0, 1'b0, 0, '0, '0);
        step();
        step();
        check1("b_rst_ready", b_ready, 1'b0);
        check1("b_rst_done", b_done, 1'b0);
        check1("b_rst_rsp", b_rsp_valid, 1'b0);
        check64("b_rst_rdata", b_rsp_rdata, 64'd0);

        rst = 1'b0;
        step();
        check1("b_noclr_ready", b_ready, 1'b1);
        check1("b_noclr_done", b_done, 1'b1);
        repeat (DEPTH - 1) step();
        check1("a_init_ready", a_ready, 1'b1);
        check1("a_init_done_hi", a_done, 1'b1);

        for (int i = 0; i < 15; i++) begin
            if (vt[i].we) begin
                drive_a(1'b1, 1'b1, vt[i].addr, vt[i].wdata, vt[i].wmask);
                step();
                drive_a(1'b0, 1'b0, 0, '0, '0);
            end else begin
                read_chk($sformatf("vec%0d", i), vt[i].addr, vt[i].exp);
            end
        end

        // Back-to-back reads, then a write slipped in behind the first read.
        drive_a(1'b1, 1'b0, 48, '0, '0); step();
        drive_a(1'b1, 1'b0, 49, '0, '0); step();
        drive_a(1'b1, 1'b0, 48, '0, '0); step();
        drive_a(1'b0, 1'b0, 0, '0, '0);
        collect("burst_rrr", 64'd77, 64'd1, 64'd77, 1, 1);

        drive_a(1'b1, 1'b0, 48, '0, '0);     step();
        drive_a(1'b1, 1'b1, 48, 64'd9, 8'hFF); step();
        drive_a(1'b1, 1'b0, 49, '0, '0);     step();
        drive_a(1'b1, 1'b0, 48, '0, '0);     step();
        drive_a(1'b0, 1'b0, 0, '0, '0);
        collect("burst_rwrr", 64'd77, 64'd1, 64'd9, 2, 1);

        for (int k = 0; k < 1500; k++) begin
            drive_a($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 9) == 0) ? 1023 : int'($urandom_range(0, 15)),
                    {$urandom(), $urandom()}, 8'($urandom_range(0, 255)));
            step();
        end
        drive_a(1'b0, 1'b0, 0, '0, '0);
        repeat (LAT + 2) step();

        // Blocking instance: writes keep ready high, a read holds ready low until its response.
        drive_b(1'b1, 1'b1, 3, 64'h55, 8'hFF); step();
        check1("b_wr1_ready", b_ready, 1'b1);
        drive_b(1'b1, 1'b1, 4, 64'h66, 8'hFF); step();
        check1("b_wr2_ready", b_ready, 1'b1);
        drive_b(1'b1, 1'b0, 3, '0, '0); step();
        check1("b_wait_ready0", b_ready, 1'b0);
        drive_b(1'b1, 1'b0, 4, '0, '0);
        for (int k = 1; k < LAT - 1; k++) begin
            step();
            check1($sformatf("b_wait_ready%0d", k), b_ready, 1'b0);
            check1($sformatf("b_wait_rsp%0d", k), b_rsp_valid, 1'b0);
        end
        step();
        check1("b_rel_ready", b_ready, 1'b1);
        check1("b_rel_rsp", b_rsp_valid, 1'b1);
        check64("b_rel_rdata", b_rsp_rdata, 64'h55);
        step();
        check1("b_second_acc", b_ready, 1'b0);
        check1("b_rsp_pulse", b_rsp_valid, 1'b0);
        check64("b_rsp_hold", b_rsp_rdata, 64'h55);
        drive_b(1'b0, 1'b0, 0, '0, '0);
        begin
            int lat_b;
            lat_b = -1;
            for (int k = 1; k <= 10 && lat_b < 0; k++) begin
                step();
                if (b_rsp_valid) begin
                    lat_b = k;
                    check64("b_second_rdata", b_rsp_rdata, 64'h66);
                end
            end
            check_int("b_second_lat", lat_b, LAT - 1);
        end

        // Reset two edges after a read is accepted; that read must never respond.
        drive_a(1'b1, 1'b0, 48, '0, '0); step();
        drive_a(1'b0, 1'b0, 0, '0, '0);  step();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check1("rst_mid_done", a_done, 1'b0);
        drive_a(1'b1, 1'b1, 0, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
        repeat (DEPTH) step();
        drive_a(1'b0, 1'b0, 0, '0, '0);
        check1("reinit_ready", a_ready, 1'b1);
        read_chk("post_rst_rd0", 0, 64'd0);
        read_chk("post_rst_rd48", 48, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
